// File: rtl/fb_burst_writer.sv
// Avalon-MM burst-write master: packs 32-bit pixels into 64-bit words and writes fixed-length bursts into a frame buffer.
// Optional stall/burst statistics are built when FB_BURST_WRITER_STATS_EN is defined.
module fb_burst_writer #(
    parameter logic [29:0] ADDRESS      = 30'h3800_0000,
    parameter int unsigned LENGTH       = 1536000,
    parameter int unsigned BURST_LENGTH = 8,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  buffer,
    input  logic [31:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        busy,
    output logic        done,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    input  logic        waitrequest,
    output logic [63:0] writedata,
    output logic [7:0]  byteenable,
    output logic        write,
    output logic [31:0] debug_value0,
    output logic [31:0] debug_value1
);

    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW        = AW + 1;
    localparam logic [31:0] PIX_TOTAL = 32'(LENGTH / 4);
    localparam logic [31:0] WRD_TOTAL = 32'(LENGTH / 8);
    localparam logic [31:0] BL32      = 32'(BURST_LENGTH);
    localparam logic [31:0] DEPTH32   = 32'(FIFO_DEPTH);
    localparam logic [31:0] LEN_WORDS = 32'(LENGTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [63:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    pair_lo_q;
    logic           odd_q;
    logic [31:0]    pix_left_q, pix_left_d;
    logic [31:0]    words_left_q;
    logic [7:0]     beats_left_q;
    logic [28:0]    next_addr_q;
    logic           busy_q, busy_d;
    logic           pixel_ready_q, pixel_ready_d;
    logic           done_q, write_q;
    logic [7:0]     byteenable_q, burstcount_q;
    logic [28:0]    address_q;

    logic           start_s, accept_s, push_s, pop_s, last_beat_s, final_s, fill_ok_s;
    logic [1:0]     buf_idx_s;
    logic [28:0]    base_word_s;
    logic [7:0]     blen_s;

    // Handshake decode, FIFO occupancy and frame-level next-state values
    always_comb begin
        start_s     = start && !busy_q;
        accept_s    = pixel_valid && pixel_ready_q;
        push_s      = accept_s && odd_q;
        pop_s       = write_q && !waitrequest;
        last_beat_s = pop_s && (beats_left_q == 8'd1);
        final_s     = last_beat_s && (words_left_q == 32'd1);
        buf_idx_s   = (buffer == 2'd3) ? 2'd0 : buffer;
        base_word_s = 29'((32'(ADDRESS) >> 3) + 32'(buf_idx_s) * LEN_WORDS);
        blen_s      = (words_left_q < BL32) ? words_left_q[7:0] : BL32[7:0];
        fill_ok_s   = (32'(count_q) >= {24'h0, blen_s});

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        if (start_s) begin
            pix_left_d = PIX_TOTAL;
        end else if (accept_s) begin
            pix_left_d = pix_left_q - 32'd1;
        end else begin
            pix_left_d = pix_left_q;
        end

        if (start_s) begin
            busy_d = 1'b1;
        end else if (final_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        // Computed from next-state values so a registered ready never lets the FIFO overflow
        pixel_ready_d = busy_d && (pix_left_d != 32'd0) && (32'(count_d) < DEPTH32);
    end

    // FIFO storage; emptiness is governed by the reset pointers, so the array needs no reset
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= {pixel_data, pair_lo_q};
        end
    end

    // Control FSM, counters, pixel pairing and registered bus outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pair_lo_q     <= 32'h0;
            odd_q         <= 1'b0;
            pix_left_q    <= 32'h0;
            words_left_q  <= 32'h0;
            beats_left_q  <= 8'h0;
            next_addr_q   <= 29'h0;
            busy_q        <= 1'b0;
            pixel_ready_q <= 1'b0;
            done_q        <= 1'b0;
            write_q       <= 1'b0;
            byteenable_q  <= 8'h0;
            burstcount_q  <= 8'h0;
            address_q     <= 29'h0;
        end else begin
            count_q       <= count_d;
            pix_left_q    <= pix_left_d;
            busy_q        <= busy_d;
            pixel_ready_q <= pixel_ready_d;
            done_q        <= final_s;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (accept_s) begin
                if (!odd_q) begin
                    pair_lo_q <= pixel_data;
                end
                odd_q <= ~odd_q;
            end
            if (pop_s) begin
                rd_ptr_q     <= rd_ptr_q + AW'(1'b1);
                words_left_q <= words_left_q - 32'd1;
                beats_left_q <= beats_left_q - 8'd1;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_s) begin
                        state_q      <= FILL;
                        words_left_q <= WRD_TOTAL;
                        next_addr_q  <= base_word_s;
                        odd_q        <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FILL: begin
                    if (fill_ok_s) begin
                        state_q      <= BURST;
                        address_q    <= next_addr_q;
                        burstcount_q <= blen_s;
                        beats_left_q <= blen_s;
                    end
                end
                BURST: begin
                    // Write rises one cycle after entry and then holds until the final beat
                    if (!write_q) begin
                        write_q      <= 1'b1;
                        byteenable_q <= 8'hFF;
                    end else if (last_beat_s) begin
                        write_q      <= 1'b0;
                        byteenable_q <= 8'h00;
                        next_addr_q  <= next_addr_q + 29'(burstcount_q);
                        state_q      <= (words_left_q == 32'd1) ? DONE : FILL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef FB_BURST_WRITER_STATS_EN
    logic [31:0] stall_cnt_q, burst_cnt_q;

    // Saturating stall-cycle and completed-burst counters, cleared at frame start
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'h0;
            burst_cnt_q <= 32'h0;
        end else if (start_s) begin
            stall_cnt_q <= 32'h0;
            burst_cnt_q <= 32'h0;
        end else begin
            if (write_q && waitrequest && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (last_beat_s && (burst_cnt_q != 32'hFFFF_FFFF)) begin
                burst_cnt_q <= burst_cnt_q + 32'd1;
            end
        end
    end

    assign debug_value0 = stall_cnt_q;
    assign debug_value1 = burst_cnt_q;
`else
    assign debug_value0 = 32'h0;
    assign debug_value1 = 32'h0;
`endif

    assign pixel_ready = pixel_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign address     = address_q;
    assign burstcount  = burstcount_q;
    assign write       = write_q;
    assign byteenable  = byteenable_q;
    assign writedata   = write_q ? fifo_mem[rd_ptr_q] : 64'h0;

endmodule

// File: tb/tb_fb_burst_writer.sv
// Bench for fb_burst_writer: a table of frame scenarios run against two parameterisations, with a beat scoreboard.
module tb_fb_burst_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start_v, sel, waitrequest, pixel_valid;
    logic [1:0]  buffer;
    logic [31:0] pixel_data;
    logic        a_start, b_start;
    assign a_start = start_v & ~sel;
    assign b_start = start_v & sel;

    logic        a_ready, a_busy, a_done, a_write, b_ready, b_busy, b_done, b_write;
    logic [28:0] a_addr, b_addr;
    logic [7:0]  a_bc, b_bc, a_be, b_be;
    logic [63:0] a_wd, b_wd;
    logic [31:0] a_d0, a_d1, b_d0, b_d1;

    fb_burst_writer #(.LENGTH(64), .BURST_LENGTH(4), .FIFO_DEPTH(16)) dut_a (
        .clock(clk), .reset_n(reset_n), .start(a_start), .buffer(buffer),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid & ~sel), .pixel_ready(a_ready),
        .busy(a_busy), .done(a_done), .address(a_addr), .burstcount(a_bc),
        .waitrequest(waitrequest), .writedata(a_wd), .byteenable(a_be), .write(a_write),
        .debug_value0(a_d0), .debug_value1(a_d1));

    fb_burst_writer #(.LENGTH(40), .BURST_LENGTH(4), .FIFO_DEPTH(16)) dut_b (
        .clock(clk), .reset_n(reset_n), .start(b_start), .buffer(buffer),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid & sel), .pixel_ready(b_ready),
        .busy(b_busy), .done(b_done), .address(b_addr), .burstcount(b_bc),
        .waitrequest(waitrequest), .writedata(b_wd), .byteenable(b_be), .write(b_write),
        .debug_value0(b_d0), .debug_value1(b_d1));

    logic        m_ready, m_busy, m_done, m_write;
    logic [28:0] m_addr;
    logic [7:0]  m_bc, m_be;
    logic [63:0] m_wd;
    logic [31:0] m_d0, m_d1;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_write = sel ? b_write : a_write;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_bc    = sel ? b_bc    : a_bc;
    assign m_be    = sel ? b_be    : a_be;
    assign m_wd    = sel ? b_wd    : a_wd;
    assign m_d0    = sel ? b_d0    : a_d0;
    assign m_d1    = sel ? b_d1    : a_d1;

    typedef struct {
        logic        use_b;
        logic [1:0]  bufsel;
        logic        stall;
        int          npix;
        logic [28:0] base;
        int          bursts;
        int          rst_beat;
        logic        restart;
    } vec_t;

    vec_t        vecs [9];
    logic [63:0] exp_wd_q [$];
    logic [28:0] exp_addr_q [$];
    logic [7:0]  exp_cnt_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int          words, off, cnt, pix_sent, beats_rem, beats_total, stalls;
        int          acc7_cyc, first_wr_cyc, done_cnt;
        logic [31:0] lo;
        logic        prev_stall, ready_chk_done, aborted;
        logic [63:0] prev_wd, exp_wd;
        logic [28:0] exp_a;
        logic [7:0]  exp_c;
        sel = v.use_b;
        buffer = v.bufsel;
        exp_wd_q.delete();
        exp_addr_q.delete();
        exp_cnt_q.delete();
        words = v.npix / 2;
        off = 0;
        while (off < words) begin
            cnt = (words - off < 4) ? words - off : 4;
            exp_addr_q.push_back(v.base + 29'(off));
            exp_cnt_q.push_back(8'(cnt));
            off += cnt;
        end
        pix_sent = 0; beats_rem = 0; beats_total = 0; stalls = 0; done_cnt = 0;
        acc7_cyc = -100; first_wr_cyc = -1; lo = 32'h0;
        prev_stall = 1'b0; ready_chk_done = 1'b0; aborted = 1'b0; prev_wd = 64'h0;
        start_v = 1'b1;
        for (int cyc = 0; cyc < 600 && done_cnt == 0 && !aborted; cyc++) begin
            tick();
            start_v = v.restart && (cyc == 10);
            if (cyc == 0) chk("busy_after_start", {63'h0, m_busy}, 64'h1);
            if (m_done) done_cnt++;
            if (prev_stall) chk("wd_stable_in_stall", m_wd, prev_wd);
            if (beats_rem != 0) chk("write_no_gap", {63'h0, m_write}, 64'h1);
            if (pix_sent == v.npix && !ready_chk_done) begin
                chk("ready_drop_after_frame", {63'h0, m_ready}, 64'h0);
                ready_chk_done = 1'b1;
            end
            if (pix_sent < v.npix) begin
                pixel_valid = 1'b1;
                pixel_data = 32'(pix_sent);
                if (m_ready) begin
                    if (pix_sent % 2 == 1) exp_wd_q.push_back({pixel_data, lo});
                    else lo = pixel_data;
                    if (pix_sent == 7) acc7_cyc = cyc;
                    pix_sent++;
                end
            end else begin
                pixel_valid = 1'b0;
            end
            waitrequest = v.stall ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_write && first_wr_cyc < 0) begin
                first_wr_cyc = cyc;
                chk("first_write_latency", 64'(cyc - acc7_cyc), 64'd3);
            end
            prev_stall = m_write && waitrequest;
            prev_wd = m_wd;
            if (prev_stall) stalls++;
            if (m_write && !waitrequest) begin
                if (v.rst_beat == beats_total) begin
                    reset_n = 1'b0;
                    aborted = 1'b1;
                end else begin
                    if (beats_rem == 0) begin
                        if (exp_addr_q.size() == 0) begin
                            chk("unexpected_burst", 64'h1, 64'h0);
                            beats_rem = 1;
                        end else begin
                            exp_a = exp_addr_q.pop_front();
                            exp_c = exp_cnt_q.pop_front();
                            chk("burst_address", 64'(m_addr), 64'(exp_a));
                            chk("burst_count", 64'(m_bc), 64'(exp_c));
                            beats_rem = int'(exp_c);
                        end
                    end
                    if (exp_wd_q.size() == 0) begin
                        chk("unexpected_beat", 64'h1, 64'h0);
                    end else begin
                        exp_wd = exp_wd_q.pop_front();
                        chk("beat_writedata", m_wd, exp_wd);
                    end
                    chk("byteenable", 64'(m_be), 64'hFF);
                    beats_rem--;
                    beats_total++;
                end
            end
        end
        if (aborted) begin
            tick();
            chk("reset_mid_burst_write", {63'h0, m_write}, 64'h0);
            chk("reset_mid_burst_busy", {63'h0, m_busy}, 64'h0);
            chk("reset_mid_burst_ready", {63'h0, m_ready}, 64'h0);
            chk("reset_mid_burst_addr", 64'(m_addr), 64'h0);
            reset_n = 1'b1;
        end else begin
            chk("done_seen", 64'(done_cnt), 64'd1);
            chk("busy_low_at_done", {63'h0, m_busy}, 64'h0);
            chk("words_outstanding", 64'(exp_wd_q.size()), 64'h0);
            chk("bursts_outstanding", 64'(exp_addr_q.size()), 64'h0);
`ifdef FB_BURST_WRITER_STATS_EN
            chk("stall_counter", 64'(m_d0), 64'(stalls));
            chk("burst_counter", 64'(m_d1), 64'(v.bursts));
`else
            chk("stall_counter_tied", 64'(m_d0), 64'h0);
            chk("burst_counter_tied", 64'(m_d1), 64'h0);
`endif
            waitrequest = 1'b0;
            tick();
            chk("done_one_cycle", {63'h0, m_done}, 64'h0);
        end
        pixel_valid = 1'b0;
        waitrequest = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd0, 1'b0, 16, 29'h0700_0000, 2, -1, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 1'b1, 16, 29'h0700_0000, 2, -1, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 1'b0, 10, 29'h0700_0000, 2, -1, 1'b0};
        vecs[3] = '{1'b0, 2'd2, 1'b1, 16, 29'h0700_0010, 2, -1, 1'b1};
        vecs[4] = '{1'b0, 2'd0, 1'b0, 16, 29'h0700_0000, 2,  2, 1'b0};
        vecs[5] = '{1'b0, 2'd0, 1'b1, 16, 29'h0700_0000, 2, -1, 1'b0};
        vecs[6] = '{1'b0, 2'd3, 1'b0, 16, 29'h0700_0000, 2, -1, 1'b0};
        vecs[7] = '{1'b0, 2'd1, 1'b1, 16, 29'h0700_0008, 2, -1, 1'b0};
        vecs[8] = '{1'b1, 2'd1, 1'b1, 10, 29'h0700_0005, 2, -1, 1'b0};

        reset_n = 1'b0; start_v = 1'b0; sel = 1'b0; waitrequest = 1'b0;
        pixel_valid = 1'b0; buffer = 2'd0; pixel_data = 32'h0;
        tick(); tick(); tick();
        chk("rst_a_write", {63'h0, a_write}, 64'h0);
        chk("rst_a_ready", {63'h0, a_ready}, 64'h0);
        chk("rst_a_busy", {63'h0, a_busy}, 64'h0);
        chk("rst_a_done", {63'h0, a_done}, 64'h0);
        chk("rst_a_address", 64'(a_addr), 64'h0);
        chk("rst_a_burstcount", 64'(a_bc), 64'h0);
        chk("rst_a_writedata", a_wd, 64'h0);
        chk("rst_a_debug0", 64'(a_d0), 64'h0);
        chk("rst_a_debug1", 64'(a_d1), 64'h0);
        chk("rst_b_write", {63'h0, b_write}, 64'h0);
        chk("rst_b_ready", {63'h0, b_ready}, 64'h0);
        chk("rst_b_busy", {63'h0, b_busy}, 64'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i]);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
